fifo_rd_ctrl: RTL

Parametrised read-side controller for the async FIFO, operating entirely in the read clock domain.
- Owns the binary read pointer, the RAM read address and the Gray-coded read pointer exported to the write-domain synchroniser.
- Generates registered EMPTY, ALMOST_EMPTY, an occupancy count and an underflow pulse, using the write pointer already synchronised into the read domain.
- Successor to the fixed 4-bit read logic: any depth 2^ADDR_WD, arithmetic Gray conversion, glitch-free registered outputs.

---
 rtl/fifo_rd_ctrl_pkg.sv | 28 ++
 rtl/fifo_rd_ctrl_if.sv | 32 +++
 rtl/fifo_rd_ctrl_gray2bin_dec.sv | 16 +
 rtl/fifo_rd_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl_pkg : shared async-FIFO constants and Gray-code helpers
// Revision: 1.0
// ============================================================================
package fifo_rd_ctrl_pkg;

   localparam int c_ADDR_WD = 3;

   // Width-agnostic: callers zero-extend to 32 bits and truncate the result.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] b;
      b = '0;
      for (int i = 31; i >= 0; i--) begin
         if (i == w - 1)
            b[i] = g[i];
         else if (i < w - 1)
            b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl_if : read-side handshake and status bundle of the async FIFO
// Revision: 1.0
// ============================================================================
interface fifo_rd_ctrl_if
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int ADDR_WD = c_ADDR_WD
);
   logic               R_INC;
   logic [ADDR_WD:0]   w2r_ptr;
   logic [ADDR_WD:0]   gray_rd_ptr;
   logic [ADDR_WD-1:0] rd_addr;
   logic               EMPTY;
   logic               ALMOST_EMPTY;
   logic [ADDR_WD:0]   RD_LEVEL;
   logic               RD_ACK;
   logic               UNDERFLOW;

   // master: the read-side user; slave: the controller itself
   modport master (
      output R_INC, w2r_ptr,
      input  gray_rd_ptr, rd_addr, EMPTY, ALMOST_EMPTY, RD_LEVEL, RD_ACK, UNDERFLOW
   );

   modport slave (
      input  R_INC, w2r_ptr,
      output gray_rd_ptr, rd_addr, EMPTY, ALMOST_EMPTY, RD_LEVEL, RD_ACK, UNDERFLOW
   );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_ctrl_gray2bin_dec.sv
`default_nettype none
// ============================================================================
// gray2bin_dec : combinational Gray-to-binary prefix-XOR decoder
// Revision: 1.0
// ============================================================================
module gray2bin_dec #(
   parameter int WIDTH = 4
) (
   input  wire logic [WIDTH-1:0] gray,
   output logic      [WIDTH-1:0] bin
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end
endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl : read-domain pointer, Gray export and registered status flags
// Revision: 1.0
// ============================================================================
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int ADDR_WD   = c_ADDR_WD,
   parameter int AEMPTY_TH = 2
) (
   input  wire logic          R_CLK,
   input  wire logic          R_RST,
   fifo_rd_ctrl_if.slave      bus
);
   localparam int c_PW = ADDR_WD + 1;

   logic [c_PW-1:0]    r_rd_ptr;
   logic [c_PW-1:0]    r_gray_rd_ptr;
   logic [ADDR_WD-1:0] r_rd_addr;
   logic [c_PW-1:0]    r_rd_level;
   logic               r_empty;
   logic               r_almost_empty;
   logic               r_rd_ack;
   logic               r_underflow;

   logic               w_rd_en;
   logic [c_PW-1:0]    w_rd_ptr_next;
   logic [c_PW-1:0]    w_gray_next;
   logic [c_PW-1:0]    w_wr_bin;
   logic [c_PW-1:0]    w_level_next;

   gray2bin_dec #(
      .WIDTH (c_PW)
   ) u_w2r_dec (
      .gray  (bus.w2r_ptr),
      .bin   (w_wr_bin)
   );

   // Read acceptance uses the registered flag, so RD_ACK and UNDERFLOW exclude each other.
   assign w_rd_en       = bus.R_INC & ~r_empty;
   assign w_rd_ptr_next = r_rd_ptr + c_PW'(w_rd_en);
   assign w_gray_next   = c_PW'(bin2gray(32'(w_rd_ptr_next)));
   assign w_level_next  = w_wr_bin - w_rd_ptr_next;

   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) begin
         r_rd_ptr       <= '0;
         r_gray_rd_ptr  <= '0;
         r_rd_addr      <= '0;
         r_rd_level     <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_rd_ack       <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_rd_ptr       <= w_rd_ptr_next;
         r_gray_rd_ptr  <= w_gray_next;
         r_rd_addr      <= w_rd_ptr_next[ADDR_WD-1:0];
         r_rd_level     <= w_level_next;
         // Comparing in Gray space lets EMPTY assert on the edge that drains the last entry.
         r_empty        <= (w_gray_next == bus.w2r_ptr);
         r_almost_empty <= (w_level_next <= c_PW'(AEMPTY_TH));
         r_rd_ack       <= w_rd_en;
         r_underflow    <= bus.R_INC & r_empty;
      end
   end

   assign bus.gray_rd_ptr  = r_gray_rd_ptr;
   assign bus.rd_addr      = r_rd_addr;
   assign bus.RD_LEVEL     = r_rd_level;
   assign bus.EMPTY        = r_empty;
   assign bus.ALMOST_EMPTY = r_almost_empty;
   assign bus.RD_ACK       = r_rd_ack;
   assign bus.UNDERFLOW    = r_underflow;
endmodule
`default_nettype wire
